// File: rtl/eth_pkg.sv
// Shared Ethernet constants: RMII dibit codes, CRC-32 parameters, receive FSM
// state encodings and default frame length limits.
package eth_pkg;

    localparam logic [1:0] DIBIT_PRE      = 2'b01;
    localparam logic [1:0] DIBIT_SFD_LAST = 2'b11;

    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;

    localparam int ETH_MIN_FRAME_LEN = 64;
    localparam int ETH_MAX_FRAME_LEN = 1522;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_IDLE     = 3'd0;
    localparam rx_state_t RX_PREAMBLE = 3'd1;
    localparam rx_state_t RX_DATA     = 3'd2;
    localparam rx_state_t RX_DONE     = 3'd3;
    localparam rx_state_t RX_DROP     = 3'd4;

    // One byte through the reflected CRC-32, data bits consumed LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  byte_in);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ byte_in[i])
                c = (c >> 1) ^ CRC_POLY_REFL;
            else
                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 register with synchronous init and enable; shared
// by the receive and transmit paths.
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data_in,
    output logic [31:0] crc
);

    logic [31:0] crc_next;

    assign crc_next = crc32_byte(crc, data_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= CRC_INIT;
        else if (init)
            crc <= CRC_INIT;
        else if (en)
            crc <= crc_next;
    end

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: strips preamble/SFD, packs dibits LSB first into
// bytes, and reports length, FCS and error status once per frame.
module rmii_rx_deframer
    import eth_pkg::*;
#(
    parameter int MAX_FRAME_LEN       = ETH_MAX_FRAME_LEN,
    parameter int MIN_FRAME_LEN       = ETH_MIN_FRAME_LEN,
    parameter int PREAMBLE_MIN_DIBITS = 4
) (
    input  logic        clk_50_mhz,
    input  logic        rst_n,
    input  logic        crs_dv,
    input  logic [1:0]  rx_d,
    input  logic        rx_er,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        sof,
    output logic        frame_done,
    output logic [15:0] frame_len,
    output logic        fcs_ok,
    output logic        err_align,
    output logic        err_rx,
    output logic        err_len
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic        crs_p0, crs_p1;
    logic [1:0]  rxd_p0, rxd_p1;
    logic        rxer_p0, rxer_p1;

    rx_state_t   state;
    logic [3:0]  pre_cnt;
    logic [1:0]  idx;
    logic [5:0]  byte_q;
    logic [15:0] byte_cnt;
    logic        err_rx_q;
    logic        carrier_end;
    logic        byte_done;
    logic [7:0]  byte_full;
    logic [31:0] crc;
    logic [31:0] crc_rev;

    // p0: pin register; p1: one dibit of lookahead for the carrier filter
    always_ff @(posedge clk_50_mhz or negedge rst_n) begin
        if (!rst_n) begin
            crs_p0  <= 1'b0;
            rxd_p0  <= 2'b00;
            rxer_p0 <= 1'b0;
            crs_p1  <= 1'b0;
            rxd_p1  <= 2'b00;
            rxer_p1 <= 1'b0;
        end else begin
            crs_p0  <= crs_dv;
            rxd_p0  <= rx_d;
            rxer_p0 <= rx_er;
            crs_p1  <= crs_p0;
            rxd_p1  <= rxd_p0;
            rxer_p1 <= rxer_p0;
        end
    end

    // A lone low cycle is an RMII toggle; two in a row end the carrier.
    assign carrier_end = !crs_p1 && !crs_p0;
    assign byte_done   = (state == RX_DATA) && !carrier_end && (idx == 2'd3);
    assign byte_full   = {rxd_p1, byte_q};

    eth_crc32 u_crc (
        .clk     (clk_50_mhz),
        .rst_n   (rst_n),
        .init    (state == RX_IDLE),
        .en      (byte_done),
        .data_in (byte_full),
        .crc     (crc)
    );

    // The residue constant is MSB-first; the reflected register holds it bit-reversed.
    always_comb begin
        crc_rev = '0;
        for (int i = 0; i < 32; i++)
            crc_rev[i] = crc[31-i];
    end

    // FSM stage: consumes the p1 dibit
    always_ff @(posedge clk_50_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            pre_cnt    <= 4'd0;
            idx        <= 2'd0;
            byte_q     <= 6'd0;
            byte_cnt   <= 16'd0;
            err_rx_q   <= 1'b0;
            data       <= 8'd0;
            data_valid <= 1'b0;
            sof        <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= 16'd0;
            fcs_ok     <= 1'b0;
            err_align  <= 1'b0;
            err_rx     <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            sof        <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                RX_IDLE: begin
                    pre_cnt  <= 4'd0;
                    idx      <= 2'd0;
                    byte_q   <= 6'd0;
                    byte_cnt <= 16'd0;
                    err_rx_q <= 1'b0;
                    if (rxer_p1)
                        state <= RX_DROP;
                    else if (crs_p1 && rxd_p1 == DIBIT_PRE) begin
                        state   <= RX_PREAMBLE;
                        pre_cnt <= 4'd1;
                    end
                end
                RX_PREAMBLE: begin
                    if (carrier_end)
                        state <= RX_IDLE;
                    else if (rxer_p1)
                        state <= RX_DROP;
                    else begin
                        case (rxd_p1)
                            DIBIT_PRE: pre_cnt <= sat_inc4(pre_cnt);
                            2'b00:     pre_cnt <= pre_cnt;
                            DIBIT_SFD_LAST: begin
                                if (int'(pre_cnt) >= PREAMBLE_MIN_DIBITS) begin
                                    state <= RX_DATA;
                                    idx   <= 2'd0;
                                end else
                                    state <= RX_DROP;
                            end
                            default:   state <= RX_DROP;
                        endcase
                    end
                end
                RX_DATA: begin
                    if (carrier_end)
                        state <= RX_DONE;
                    else begin
                        if (rxer_p1)
                            err_rx_q <= 1'b1;
                        if (idx != 2'd3)
                            byte_q[{idx, 1'b0} +: 2] <= rxd_p1;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            byte_cnt <= sat_inc16(byte_cnt);
                            if (int'(byte_cnt) < MAX_FRAME_LEN) begin
                                data       <= byte_full;
                                data_valid <= 1'b1;
                                sof        <= (byte_cnt == 16'd0);
                            end
                        end
                    end
                end
                RX_DONE: begin
                    frame_done <= 1'b1;
                    frame_len  <= byte_cnt;
                    fcs_ok     <= (crc_rev == CRC_RESIDUE);
                    err_align  <= (idx != 2'd0);
                    err_rx     <= err_rx_q;
                    err_len    <= (int'(byte_cnt) < MIN_FRAME_LEN) ||
                                  (int'(byte_cnt) > MAX_FRAME_LEN);
                    state      <= RX_IDLE;
                end
                RX_DROP: begin
                    if (carrier_end)
                        state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Scoreboard bench for rmii_rx_deframer: stimulus pushes expected bytes and
// frame status, a monitor pops and compares on every strobe.
module tb_rmii_rx_deframer;

    logic        clk_50_mhz = 1'b0;
    logic        rst_n      = 1'b0;
    logic        crs_dv     = 1'b0;
    logic [1:0]  rx_d       = 2'b00;
    logic        rx_er      = 1'b0;
    logic [7:0]  data;
    logic        data_valid;
    logic        sof;
    logic        frame_done;
    logic [15:0] frame_len;
    logic        fcs_ok;
    logic        err_align;
    logic        err_rx;
    logic        err_len;

    rmii_rx_deframer dut (
        .clk_50_mhz (clk_50_mhz),
        .rst_n      (rst_n),
        .crs_dv     (crs_dv),
        .rx_d       (rx_d),
        .rx_er      (rx_er),
        .data       (data),
        .data_valid (data_valid),
        .sof        (sof),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .fcs_ok     (fcs_ok),
        .err_align  (err_align),
        .err_rx     (err_rx),
        .err_len    (err_len)
    );

    always #10 clk_50_mhz = ~clk_50_mhz;

    typedef struct packed {
        logic [7:0] b;
        logic       s;
    } exp_byte_t;

    typedef struct packed {
        logic [15:0] len;
        logic        ok;
        logic        al;
        logic        rx;
        logic        ln;
    } exp_stat_t;

    exp_byte_t  qb[$];
    exp_stat_t  qs[$];
    logic [7:0] frm[$];
    int         total = 0;
    int         bad   = 0;

    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // Payload of n bytes starting A5, FF, then a ramp; FCS appended LSB first.
    task automatic build(input int n, input bit flip);
        logic [31:0] c;
        logic [7:0]  b;
        frm.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            b = (i == 0) ? 8'hA5 : (i == 1) ? 8'hFF : 8'(i * 37 + 11);
            frm.push_back(b);
            c = crc_model(c, b);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) begin
            b = c[8*k +: 8];
            frm.push_back(b);
        end
        if (flip) frm[5] = frm[5] ^ 8'h10;
    endtask

    task automatic dib(input logic c, input logic [1:0] d, input logic e);
        @(negedge clk_50_mhz);
        crs_dv = c;
        rx_d   = d;
        rx_er  = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) dib(1'b0, 2'b00, 1'b0);
    endtask

    // tog_at/er_at: dibit index with crs_dv low / rx_er high; cut: stop after that many bytes.
    task automatic send_frame(input int tog_at, input int er_at, input int extra, input int cut);
        logic [7:0] b;
        for (int i = 0; i < 7; i++) dib(1'b1, 2'b01, 1'b0);
        dib(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            if (i == cut) break;
            b = frm[i];
            if (i < 1522) qb.push_back('{b: b, s: (i == 0)});
            for (int k = 0; k < 4; k++)
                dib((4*i+k) != tog_at, b[2*k +: 2], (4*i+k) == er_at);
        end
        if (cut >= 0) begin
            for (int k = 0; k < 3; k++) dib(1'b1, 2'b00, 1'b0);
        end else begin
            for (int k = 0; k < extra; k++) dib(1'b1, 2'b00, 1'b0);
            idle(6);
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({data, data_valid, sof, frame_done, frame_len, fcs_ok, err_align, err_rx, err_len} != '0) begin
            bad++;
            $display("FAIL %s: outputs data=%h dv=%b sof=%b fd=%b len=%0d ok=%b al=%b rx=%b ln=%b, required all zero",
                     name, data, data_valid, sof, frame_done, frame_len, fcs_ok, err_align, err_rx, err_len);
        end
    endtask

    initial begin : monitor
        exp_byte_t eb;
        exp_stat_t es;
        forever begin
            @(negedge clk_50_mhz);
            if (rst_n && data_valid) begin
                total++;
                if (qb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_byte: got data=%h sof=%b, required no strobe", data, sof);
                end else begin
                    eb = qb.pop_front();
                    if (data !== eb.b || sof !== eb.s) begin
                        bad++;
                        $display("FAIL byte: got data=%h sof=%b, required data=%h sof=%b", data, sof, eb.b, eb.s);
                    end
                end
            end
            if (rst_n && frame_done) begin
                total++;
                if (qs.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_status: got len=%0d, required no frame_done", frame_len);
                end else begin
                    es = qs.pop_front();
                    if ({frame_len, fcs_ok, err_align, err_rx, err_len} !== es) begin
                        bad++;
                        $display("FAIL status: got len=%0d ok=%b al=%b rx=%b ln=%b, required len=%0d ok=%b al=%b rx=%b ln=%b",
                                 frame_len, fcs_ok, err_align, err_rx, err_len, es.len, es.ok, es.al, es.rx, es.ln);
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [7:0]  chk [9];
        logic [31:0] c;
        chk = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) c = crc_model(c, chk[i]);
        total++;
        if (~c != 32'hCBF43926) begin
            bad++;
            $display("FAIL crc_model: got %h, required cbf43926", ~c);
        end

        repeat (3) @(negedge clk_50_mhz);
        check_zero("reset_held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50_mhz);
        check_zero("reset_released");

        // good 64-byte frame
        build(60, 1'b0);
        qs.push_back('{len: 16'd64, ok: 1'b1, al: 1'b0, rx: 1'b0, ln: 1'b0});
        send_frame(-1, -1, 0, -1);

        // one payload bit flipped
        build(60, 1'b1);
        qs.push_back('{len: 16'd64, ok: 1'b0, al: 1'b0, rx: 1'b0, ln: 1'b0});
        send_frame(-1, -1, 0, -1);

        // two trailing dibits past the last byte
        build(60, 1'b0);
        qs.push_back('{len: 16'd64, ok: 1'b1, al: 1'b1, rx: 1'b0, ln: 1'b0});
        send_frame(-1, -1, 2, -1);

        // single-cycle crs_dv toggle mid-frame
        qs.push_back('{len: 16'd64, ok: 1'b1, al: 1'b0, rx: 1'b0, ln: 1'b0});
        send_frame(4*30+2, -1, 0, -1);

        // rx_er inside data
        qs.push_back('{len: 16'd64, ok: 1'b1, al: 1'b0, rx: 1'b1, ln: 1'b0});
        send_frame(-1, 4*20+1, 0, -1);

        // short frame ended by a two-cycle low
        build(36, 1'b0);
        qs.push_back('{len: 16'd40, ok: 1'b1, al: 1'b0, rx: 1'b0, ln: 1'b1});
        send_frame(-1, -1, 0, -1);

        // short preamble, false carrier, rx_er in preamble: all silent
        dib(1'b1, 2'b01, 1'b0); dib(1'b1, 2'b01, 1'b0); dib(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 8; i++) begin
            dib(1'b1, 2'b01, 1'b0); dib(1'b1, 2'b01, 1'b0);
            dib(1'b1, 2'b10, 1'b0); dib(1'b1, 2'b10, 1'b0);
        end
        idle(6);
        for (int i = 0; i < 4; i++) dib(1'b1, 2'b10, 1'b0);
        idle(6);
        for (int i = 0; i < 5; i++) dib(1'b1, 2'b01, 1'b0);
        dib(1'b1, 2'b01, 1'b1); dib(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 16; i++) dib(1'b1, 2'b11, 1'b0);
        idle(6);

        // oversize frame
        build(1596, 1'b0);
        qs.push_back('{len: 16'd1600, ok: 1'b1, al: 1'b0, rx: 1'b0, ln: 1'b1});
        send_frame(-1, -1, 0, -1);

        // reset mid-frame, then a clean frame
        build(60, 1'b0);
        send_frame(-1, -1, 0, 10);
        @(negedge clk_50_mhz);
        rst_n  = 1'b0;
        crs_dv = 1'b0;
        rx_d   = 2'b00;
        #1;
        check_zero("reset_midframe");
        repeat (2) @(negedge clk_50_mhz);
        rst_n = 1'b1;
        idle(4);
        qs.push_back('{len: 16'd64, ok: 1'b1, al: 1'b0, rx: 1'b0, ln: 1'b0});
        send_frame(-1, -1, 0, -1);

        idle(20);
        total++;
        if (qb.size() != 0) begin
            bad++;
            $display("FAIL leftover_bytes: %0d expected bytes never strobed, required 0", qb.size());
        end
        total++;
        if (qs.size() != 0) begin
            bad++;
            $display("FAIL leftover_status: %0d expected frame_done never seen, required 0", qs.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
